matrix_3x3_gen: RTL and testbench

- Producer side of the 3x3 window interface used by the image filters (Gaussian, Sobel and similar).
- Accepts a raster pixel stream, one pixel per accepted cycle, and buffers the two previous rows in on-chip line memories.
- Emits a 3x3 neighbourhood (matrix_p11..matrix_p33) with matrix_clken, data_valid (border/invalid flag) and start, so a filter core can attach directly.

---
 rtl/matrix_3x3_gen.sv | 88 ++++++++
 tb/tb_matrix_3x3_gen.sv | 135 +++++++++++++
 2 files changed

// File: rtl/matrix_3x3_gen.sv
// matrix_3x3_gen: 3x3 window generator over a raster stream using two line buffers.
// Define MATRIX_ZERO_BORDER_EN to force the matrix outputs to zero on border windows.
module matrix_3x3_gen #(
    parameter int IMG_COLS   = 640,
    parameter int IMG_ROWS   = 512,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic [DATA_WIDTH-1:0] matrix_p11,
    output logic [DATA_WIDTH-1:0] matrix_p12,
    output logic [DATA_WIDTH-1:0] matrix_p13,
    output logic [DATA_WIDTH-1:0] matrix_p21,
    output logic [DATA_WIDTH-1:0] matrix_p22,
    output logic [DATA_WIDTH-1:0] matrix_p23,
    output logic [DATA_WIDTH-1:0] matrix_p31,
    output logic [DATA_WIDTH-1:0] matrix_p32,
    output logic [DATA_WIDTH-1:0] matrix_p33,
    output logic                  matrix_clken,
    output logic                  data_valid,
    output logic                  start,
    output logic                  frame_done
);
    localparam int CW = IMG_COLS > 2 ? $clog2(IMG_COLS) : 2;
    localparam int RW = IMG_ROWS > 2 ? $clog2(IMG_ROWS) : 2;
    logic [CW-1:0] col_cnt, col;
    logic [RW-1:0] row_cnt, row;
    logic last_col, last_pix, border;
    logic [DATA_WIDTH-1:0] lb0 [IMG_COLS];
    logic [DATA_WIDTH-1:0] lb1 [IMG_COLS];
    logic [2:0][DATA_WIDTH-1:0] col3;
    logic [2:0][2:0][DATA_WIDTH-1:0] win, win_o;
    // a sof pixel is always (0,0), whatever the counters say
    assign col      = pix_sof ? '0 : col_cnt;
    assign row      = pix_sof ? '0 : row_cnt;
    assign last_col = col == CW'(IMG_COLS - 1);
    assign last_pix = last_col && row == RW'(IMG_ROWS - 1);
    assign border   = row < RW'(2) || col < CW'(2);
    assign col3     = {pix_data, lb1[col], lb0[col]};
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb0[col] <= lb1[col];
            lb1[col] <= pix_data;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt      <= '0;
            row_cnt      <= '0;
            win          <= '0;
            matrix_clken <= 1'b0;
            data_valid   <= 1'b0;
            start        <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            matrix_clken <= pix_valid;
            frame_done   <= pix_valid && last_pix;
            if (pix_valid) begin
                col_cnt    <= last_col ? '0 : col + 1'b1;
                row_cnt    <= last_pix ? '0 : last_col ? row + 1'b1 : row;
                data_valid <= border;
                start      <= last_pix ? 1'b0 : pix_sof ? 1'b1 : start;
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                    win[i][2] <= col3[i];
                end
            end
        end
    end
`ifdef MATRIX_ZERO_BORDER_EN
    assign win_o = data_valid ? '0 : win;
`else
    assign win_o = win;
`endif
    assign matrix_p11 = win_o[0][0];
    assign matrix_p12 = win_o[0][1];
    assign matrix_p13 = win_o[0][2];
    assign matrix_p21 = win_o[1][0];
    assign matrix_p22 = win_o[1][1];
    assign matrix_p23 = win_o[1][2];
    assign matrix_p31 = win_o[2][0];
    assign matrix_p32 = win_o[2][1];
    assign matrix_p33 = win_o[2][2];
endmodule

// File: tb/tb_matrix_3x3_gen.sv
// tb_matrix_3x3_gen: directed checks of matrix_3x3_gen on a 4x3 image.
module tb_matrix_3x3_gen;
    logic clk = 1'b0;
    logic rst, pix_valid, pix_sof;
    logic [15:0] pix_data;
    logic [15:0] matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22, matrix_p23;
    logic [15:0] matrix_p31, matrix_p32, matrix_p33;
    logic matrix_clken, data_valid, start, frame_done;
    logic [15:0] m [3][3];
    int checks = 0, errors = 0;
    int lr, lc;
    bit exp_start, last_dv;

    matrix_3x3_gen #(.IMG_COLS(4), .IMG_ROWS(3), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
        .matrix_p11(matrix_p11), .matrix_p12(matrix_p12), .matrix_p13(matrix_p13),
        .matrix_p21(matrix_p21), .matrix_p22(matrix_p22), .matrix_p23(matrix_p23),
        .matrix_p31(matrix_p31), .matrix_p32(matrix_p32), .matrix_p33(matrix_p33),
        .matrix_clken(matrix_clken), .data_valid(data_valid), .start(start), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always_comb begin
        m[0][0] = matrix_p11; m[0][1] = matrix_p12; m[0][2] = matrix_p13;
        m[1][0] = matrix_p21; m[1][1] = matrix_p22; m[1][2] = matrix_p23;
        m[2][0] = matrix_p31; m[2][1] = matrix_p32; m[2][2] = matrix_p33;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic win_chk(input int r, input int c);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                if (r >= 2 && c >= 2)
                    chk($sformatf("p%0d%0d@%0d,%0d", i + 1, j + 1, r, c), 32'(m[i][j]),
                        32'((r - 2 + i) * 16 + (c - 2 + j)));
`ifdef MATRIX_ZERO_BORDER_EN
                else
                    chk($sformatf("zb_p%0d%0d@%0d,%0d", i + 1, j + 1, r, c), 32'(m[i][j]), 32'd0);
`endif
    endtask

    task automatic pix(input int r, input int c, input bit sof);
        bit last;
        @(negedge clk);
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_data  = 16'(r * 16 + c);
        @(posedge clk);
        #1;
        last = (r == 2 && c == 3);
        if (sof) exp_start = 1'b1;
        if (last) exp_start = 1'b0;
        last_dv = (r < 2 || c < 2);
        lr = r;
        lc = c;
        chk("clken", 32'(matrix_clken), 32'd1);
        chk("dv", 32'(data_valid), 32'(last_dv));
        chk("frame_done", 32'(frame_done), 32'(last));
        chk("start", 32'(start), 32'(exp_start));
        win_chk(r, c);
    endtask

    task automatic gap();
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        @(posedge clk);
        #1;
        chk("gap_clken", 32'(matrix_clken), 32'd0);
        chk("gap_frame_done", 32'(frame_done), 32'd0);
        chk("gap_dv", 32'(data_valid), 32'(last_dv));
        chk("gap_start", 32'(start), 32'(exp_start));
        win_chk(lr, lc);
    endtask

    task automatic frame(input bit gaps);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) begin
                pix(r, c, r == 0 && c == 0);
                if (gaps) gap();
            end
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_clken"}, 32'(matrix_clken), 32'd0);
        chk({tag, "_dv"}, 32'(data_valid), 32'd0);
        chk({tag, "_start"}, 32'(start), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                chk($sformatf("%s_p%0d%0d", tag, i + 1, j + 1), 32'(m[i][j]), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        pix_data = '0;
        exp_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_chk("reset");
        rst = 1'b0;
        frame(1'b0);
        gap();
        frame(1'b1);
        frame(1'b0);
        frame(1'b0);
        gap();
        for (int k = 0; k < 6; k++) pix(k / 4, k % 4, k == 0);
        frame(1'b0);
        gap();
        for (int k = 0; k < 6; k++) pix(k / 4, k % 4, k == 0);
        #2;
        rst = 1'b1;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        exp_start = 1'b0;
        #1;
        rst_chk("async_rst");
        @(negedge clk);
        rst = 1'b0;
        frame(1'b0);
        gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
